// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO, drained
// LSB-first onto txd by a bit serialiser with a fixed-length bit period.
module uart_tx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q;
  logic          push, pop;
  logic [7:0]    head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          txd_q, txd_d;

  // Space is judged from the registered level only, so a same-edge pop
  // never lets a push into a full FIFO.
  assign in_ready = (level_q != LVL_FULL);
  assign push     = in_valid && in_ready;
  assign level    = level_q;
  assign head     = mem[rd_ptr];
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) || (level_q != '0);

  // NOTE: the storage array is deliberately left out of reset; validity is
  // defined by the pointers and level, which keeps it mappable to RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW + 1)'(1);
        2'b01:   level_q <= level_q - (AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          cnt_d   = BIT_LAST;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          txd_d   = shift_q[0];
          idx_d   = '0;
          cnt_d   = BIT_LAST;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more bytes wait.
          if (level_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            cnt_d   = BIT_LAST;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, back-to-back frames, FIFO
// back-pressure, asynchronous reset mid-frame and the minimum bit period.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int H1 = 4;
  localparam int D1 = 4;
  localparam int H2 = 2;
  localparam int D2 = 2;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;

  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1  = '0;
  logic       in_ready1, txd1, busy1;
  logic [2:0] level1;

  logic       in_valid2 = 1'b0;
  logic [7:0] in_data2  = '0;
  logic       in_ready2, txd2, busy2;
  logic [1:0] level2;

  int n_vec   = 0;
  int n_err   = 0;
  int max_lvl = 0;
  int stalls  = 0;

  uart_tx_fifo #(.CLK_PER_HALF_BIT(H1), .FIFO_DEPTH(D1)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid1),
    .in_data  (in_data1),
    .in_ready (in_ready1),
    .txd      (txd1),
    .busy     (busy1),
    .level    (level1)
  );

  uart_tx_fifo #(.CLK_PER_HALF_BIT(H2), .FIFO_DEPTH(D2)) dut_min (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (in_valid2),
    .in_data  (in_data2),
    .in_ready (in_ready2),
    .txd      (txd2),
    .busy     (busy2),
    .level    (level2)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (int'(level1) > max_lvl) max_lvl = int'(level1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic txd_of(input int sel);
    return (sel == 0) ? txd1 : txd2;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  task automatic wait_start(input int sel, input string tag);
    int n;
    n = 0;
    while (txd_of(sel) !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_start"}, 32'(txd_of(sel)), 32'(0));
  endtask

  // Samples txd on every clock of a 10-bit frame; each bit must hold its
  // value for exactly 2*H clocks (AND and OR of samples both match).
  task automatic frame(input int sel, input logic [7:0] b, input bit pre, input string tag);
    int h;
    logic [9:0] expv, lo, hi;
    logic s;
    h    = (sel == 0) ? H1 : H2;
    expv = {1'b1, b, 1'b0};
    lo   = '1;
    hi   = '0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 2 * h; j++) begin
        if (pre || i != 0 || j != 0) step();
        s     = txd_of(sel);
        lo[i] = lo[i] & s;
        hi[i] = hi[i] | s;
      end
    end
    check({tag, "_lo"}, 32'(lo), 32'(expv));
    check({tag, "_hi"}, 32'(hi), 32'(expv));
  endtask

  task automatic finish_idle(input int sel, input string tag);
    check({tag, "_busy_last"}, 32'(busy_of(sel)), 32'(1));
    step();
    check({tag, "_busy_end"}, 32'(busy_of(sel)), 32'(0));
    check({tag, "_txd_end"}, 32'(txd_of(sel)), 32'(1));
  endtask

  task automatic test_latency();
    in_data1  = 8'h55;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    check("lat_level_k", 32'(level1), 32'(1));
    check("lat_txd_k", 32'(txd1), 32'(1));
    step();
    check("lat_txd_k1", 32'(txd1), 32'(0));
    check("lat_level_k1", 32'(level1), 32'(0));
    check("lat_busy_k1", 32'(busy1), 32'(1));
    frame(0, 8'h55, 1'b0, "f55");
    finish_idle(0, "f55");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        in_valid1 = 1'b1;
        in_data1  = 8'hA3;
        step();
        in_data1  = 8'h00;
        step();
        in_data1  = 8'hFF;
        step();
        in_valid1 = 1'b0;
      end
      begin
        wait_start(0, "b2b");
        frame(0, 8'hA3, 1'b0, "b2b_a3");
        frame(0, 8'h00, 1'b1, "b2b_00");
        frame(0, 8'hFF, 1'b1, "b2b_ff");
        finish_idle(0, "b2b");
      end
    join
  endtask

  task automatic test_backpressure();
    max_lvl = 0;
    stalls  = 0;
    fork
      begin
        bit rdy, was_full;
        int n;
        for (int v = 1; v <= 10; v++) begin
          was_full  = 1'b0;
          n         = 0;
          in_valid1 = 1'b1;
          in_data1  = 8'(v);
          do begin
            rdy = in_ready1;
            if (!rdy) begin
              was_full = 1'b1;
              stalls++;
            end else if (was_full) begin
              check("bp_pop_no_push", 32'(level1), 32'(3));
            end
            step();
            n++;
          end while (!rdy && n < 400);
          if (was_full) check("bp_refill", 32'(level1), 32'(4));
        end
        in_valid1 = 1'b0;
      end
      begin
        wait_start(0, "bp");
        for (int v = 1; v <= 10; v++) frame(0, 8'(v), v != 1, "bp_byte");
        finish_idle(0, "bp");
      end
    join
    check("bp_max_level", 32'(max_lvl), 32'(4));
    check("bp_stalled", 32'(stalls > 0), 32'(1));
  endtask

  task automatic test_reset_mid_frame();
    bit hi_all;
    in_valid1 = 1'b1;
    in_data1  = 8'h3C;
    step();
    in_data1  = 8'h11;
    step();
    in_data1  = 8'h22;
    step();
    in_valid1 = 1'b0;
    repeat (18) step();
    check("rst_pre_bit1", 32'(txd1), 32'(0));
    check("rst_pre_level", 32'(level1), 32'(2));
    #2;
    resetn = 1'b0;
    #1;
    check("rst_txd", 32'(txd1), 32'(1));
    check("rst_level", 32'(level1), 32'(0));
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_ready", 32'(in_ready1), 32'(1));
    repeat (2) step();
    @(negedge clock);
    resetn = 1'b1;
    hi_all = 1'b1;
    repeat (200) begin
      step();
      if (txd1 !== 1'b1) hi_all = 1'b0;
    end
    check("rst_after_txd_high", 32'(hi_all), 32'(1));
    check("rst_after_busy", 32'(busy1), 32'(0));
    check("rst_after_level", 32'(level1), 32'(0));
  endtask

  task automatic test_msb_only();
    in_data1  = 8'h80;
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    step();
    frame(0, 8'h80, 1'b0, "f80");
    finish_idle(0, "f80");

    in_data2  = 8'h80;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    check("min_level_k", 32'(level2), 32'(1));
    step();
    check("min_txd_k1", 32'(txd2), 32'(0));
    frame(1, 8'h80, 1'b0, "min80");
    finish_idle(1, "min80");
  endtask

  initial begin
    #12;
    check("reset_txd", 32'(txd1), 32'(1));
    check("reset_level", 32'(level1), 32'(0));
    check("reset_busy", 32'(busy1), 32'(0));
    check("reset_ready", 32'(in_ready1), 32'(1));
    check("reset_min_txd", 32'(txd2), 32'(1));
    check("reset_min_ready", 32'(in_ready2), 32'(1));
    @(negedge clock);
    resetn = 1'b1;
    step();

    test_latency();
    repeat (3) step();
    test_back_to_back();
    repeat (3) step();
    test_backpressure();
    repeat (3) step();
    test_reset_mid_frame();
    test_msb_only();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
